// File: rtl/mc_controller.sv
// Multicycle control unit for the minicpu core: decodes op/funct and sequences each
// instruction through 3-5 states, driving the ALU select and every datapath mux/enable.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_ANDIEX  = 4'd12,
        S_BNEEX   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;

    assign state = r_state;

    // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_RTYPEEX;
                        OP_BEQ:       r_state <= S_BEQEX;
                        OP_BNE:       r_state <= S_BNEEX;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_ANDI:      r_state <= S_ANDIEX;
                        OP_J:         r_state <= S_JEX;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   r_state <= S_MEMWB;
                S_RTYPEEX: r_state <= S_RTYPEWB;
                S_ADDIEX:  r_state <= S_IMMWB;
                S_ANDIEX:  r_state <= S_IMMWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        pcen       = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;

        case (r_state)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                pcen       = 1'b1;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    6'b000100: alucontrol = 3'b011;
                    default:   alucontrol = 3'b010;
                endcase
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = (r_state == S_BEQEX) ? zero : ~zero;
            end
            S_ANDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                zeroext = 1'b1;
            end
            S_IMMWB:  regwrite = 1'b1;
            S_JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase

        // Architectural side effects are suppressed while reset is held, even mid-instruction.
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its state
// sequence and compares state plus the full control vector against hand-built values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       zeroext;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .zeroext    (zeroext),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    // Control vector layout:
    // pcen iord memwrite irwrite regdst memtoreg regwrite alusrca | alusrcb zeroext pcsrc alucontrol
    logic [15:0] w_ctl;
    assign w_ctl = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                    alusrcb, zeroext, pcsrc, alucontrol};

    localparam logic [15:0] C_FETCH     = 16'b1_0_0_1_0_0_0_0_01_0_00_010;
    localparam logic [15:0] C_FETCH_RST = 16'b0_0_0_0_0_0_0_0_01_0_00_010;
    localparam logic [15:0] C_DECODE    = 16'b0_0_0_0_0_0_0_0_11_0_00_010;
    localparam logic [15:0] C_MEMADR    = 16'b0_0_0_0_0_0_0_1_10_0_00_010;
    localparam logic [15:0] C_MEMRD     = 16'b0_1_0_0_0_0_0_0_00_0_00_000;
    localparam logic [15:0] C_MEMWB     = 16'b0_0_0_0_0_1_1_0_00_0_00_000;
    localparam logic [15:0] C_MEMWR     = 16'b0_1_1_0_0_0_0_0_00_0_00_000;
    localparam logic [15:0] C_RTYPEWB   = 16'b0_0_0_0_1_0_1_0_00_0_00_000;
    localparam logic [15:0] C_BR_TAKEN  = 16'b1_0_0_0_0_0_0_1_00_0_01_110;
    localparam logic [15:0] C_BR_NOT    = 16'b0_0_0_0_0_0_0_1_00_0_01_110;
    localparam logic [15:0] C_ANDIEX    = 16'b0_0_0_0_0_0_0_1_10_1_00_000;
    localparam logic [15:0] C_IMMWB     = 16'b0_0_0_0_0_0_1_0_00_0_00_000;
    localparam logic [15:0] C_JEX       = 16'b1_0_0_0_0_0_0_0_00_0_10_000;
    localparam logic [15:0] C_RTYPE_0   = 16'b0_0_0_0_0_0_0_1_00_0_00_000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Settle, then compare both the state and the full control vector.
    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [15:0] exp_ctl);
        #1;
        check({tag, ".state"}, {12'd0, state}, {12'd0, exp_state});
        check({tag, ".ctl"}, w_ctl, exp_ctl);
    endtask

    logic [5:0] fn_tab  [6];
    logic [2:0] alu_tab [6];

    initial begin
        fn_tab  = '{6'b100000, 6'b100100, 6'b100101, 6'b000100, 6'b111111, 6'b101010};
        alu_tab = '{3'b010,    3'b000,    3'b001,    3'b011,    3'b010,    3'b111};

        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b100010;
        zero  = 1'b0;
        tick();
        tick();
        chk("rst_init", 4'd0, C_FETCH_RST);

        // Walk into RTYPEEX, then abort with a two-cycle reset.
        reset = 1'b0;
        chk("fetch_after_init", 4'd0, C_FETCH);
        tick(); chk("rt_abort_decode", 4'd1, C_DECODE);
        tick(); chk("rt_abort_ex", 4'd6, C_RTYPE_0 | 16'd6);
        reset = 1'b1;
        chk("rt_abort_ex_rst", 4'd6, C_RTYPE_0 | 16'd6);
        tick(); chk("rst_mid_1", 4'd0, C_FETCH_RST);
        tick(); chk("rst_mid_2", 4'd0, C_FETCH_RST);
        reset = 1'b0;
        chk("fetch_after_abort", 4'd0, C_FETCH);

        // R-type sub then slt.
        funct = 6'b100010;
        tick(); chk("sub_decode", 4'd1, C_DECODE);
        tick(); chk("sub_ex", 4'd6, C_RTYPE_0 | 16'b110);
        tick(); chk("sub_wb", 4'd7, C_RTYPEWB);
        tick(); chk("sub_fetch", 4'd0, C_FETCH);
        funct = 6'b101010;
        tick(); chk("slt_decode", 4'd1, C_DECODE);
        tick(); chk("slt_ex", 4'd6, C_RTYPE_0 | 16'b111);
        tick(); chk("slt_wb", 4'd7, C_RTYPEWB);
        tick(); chk("slt_fetch", 4'd0, C_FETCH);

        // Remaining funct codes, including an unknown one that still writes back.
        for (int i = 0; i < 6; i++) begin
            funct = fn_tab[i];
            tick(); chk("fn_decode", 4'd1, C_DECODE);
            tick(); chk("fn_ex", 4'd6, C_RTYPE_0 | {13'd0, alu_tab[i]});
            tick(); chk("fn_wb", 4'd7, C_RTYPEWB);
            tick(); chk("fn_fetch", 4'd0, C_FETCH);
        end

        // lw: 0,1,2,3,4,0
        op = 6'b100011;
        tick(); chk("lw_decode", 4'd1, C_DECODE);
        tick(); chk("lw_memadr", 4'd2, C_MEMADR);
        tick(); chk("lw_memrd", 4'd3, C_MEMRD);
        tick(); chk("lw_memwb", 4'd4, C_MEMWB);
        tick(); chk("lw_fetch", 4'd0, C_FETCH);

        // sw: 0,1,2,5,0
        op = 6'b101011;
        tick(); chk("sw_decode", 4'd1, C_DECODE);
        tick(); chk("sw_memadr", 4'd2, C_MEMADR);
        tick(); chk("sw_memwr", 4'd5, C_MEMWR);
        tick(); chk("sw_fetch", 4'd0, C_FETCH);

        // beq taken, then not taken with a live zero toggle.
        op = 6'b000100;
        zero = 1'b1;
        tick(); chk("beq_t_decode", 4'd1, C_DECODE);
        tick(); chk("beq_t_ex", 4'd8, C_BR_TAKEN);
        tick(); chk("beq_t_fetch", 4'd0, C_FETCH);
        zero = 1'b0;
        tick(); chk("beq_n_decode", 4'd1, C_DECODE);
        tick(); chk("beq_n_ex", 4'd8, C_BR_NOT);
        zero = 1'b1;
        chk("beq_zero_rise", 4'd8, C_BR_TAKEN);
        tick(); chk("beq_n_fetch", 4'd0, C_FETCH);

        // bne: inverse sense of zero.
        op = 6'b000101;
        zero = 1'b1;
        tick(); chk("bne_z1_decode", 4'd1, C_DECODE);
        tick(); chk("bne_z1_ex", 4'd13, C_BR_NOT);
        tick(); chk("bne_z1_fetch", 4'd0, C_FETCH);
        zero = 1'b0;
        tick(); chk("bne_z0_decode", 4'd1, C_DECODE);
        tick(); chk("bne_z0_ex", 4'd13, C_BR_TAKEN);
        tick(); chk("bne_z0_fetch", 4'd0, C_FETCH);

        // andi: 0,1,12,10,0
        op = 6'b001100;
        tick(); chk("andi_decode", 4'd1, C_DECODE);
        tick(); chk("andi_ex", 4'd12, C_ANDIEX);
        tick(); chk("andi_wb", 4'd10, C_IMMWB);
        tick(); chk("andi_fetch", 4'd0, C_FETCH);

        // addi: 0,1,9,10,0
        op = 6'b001000;
        tick(); chk("addi_decode", 4'd1, C_DECODE);
        tick(); chk("addi_ex", 4'd9, C_MEMADR);
        tick(); chk("addi_wb", 4'd10, C_IMMWB);
        tick(); chk("addi_fetch", 4'd0, C_FETCH);

        // Illegal opcode: 0,1,0 with no writes.
        op = 6'b111111;
        tick(); chk("ill_decode", 4'd1, C_DECODE);
        tick(); chk("ill_fetch", 4'd0, C_FETCH);

        // j: 0,1,11,0
        op = 6'b000010;
        tick(); chk("j_decode", 4'd1, C_DECODE);
        tick(); chk("j_ex", 4'd11, C_JEX);
        tick(); chk("j_fetch", 4'd0, C_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the minicpu core; sits directly upstream of the ALU.
- Decodes the opcode/funct fields of the instruction register and sequences one instruction over 3–5 cycles.
- Drives the ALU function select alucontrol[2:0] and every datapath mux and write-enable.
- Consumes the ALU zero flag to resolve branches.

Parameters:
- None. The encodings below are fixed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC register load enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register load enable
- regdst  output  1  write register: 0=rt, 1=rd
- memtoreg  output  1  writeback data: 0=ALUOut, 1=MDR
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU a: 0=PC, 1=regA
- alusrcb  output  2  ALU b: 00=regB, 01=4, 10=ext imm, 11=SignImm<<2
- zeroext  output  1  imm extension: 1=zero-extend, 0=sign-extend
- pcsrc  output  2  next PC: 00=ALU y, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU f: 000 and, 001 or, 010 add, 011 shl, 110 sub, 111 slt
- state  output  4  current state, for debug and verification

Behaviour:
- State register is 4 bits and the only storage element.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IMMWB=10, JEX=11, ANDIEX=12, BNEEX=13.
- Encodings 14–15 are unused; if reached, next state is FETCH and all enables are 0.
- Reset:
  - Rising clk with reset=1 loads FETCH, regardless of the current state (a mid-instruction abort is allowed).
  - While reset=1, pcen, irwrite, regwrite and memwrite are forced to 0. The other outputs follow the state.
- Outputs are combinational from state. Exception: pcen in BEQEX/BNEEX also depends on zero. Defaults are 0 unless listed.
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcen=1.
  - DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut).
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=010.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol per funct decode.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero.
  - BNEEX: same as BEQEX but pcen=~zero.
  - ADDIEX: alusrca=1, alusrcb=10, alucontrol=010.
  - ANDIEX: alusrca=1, alusrcb=10, zeroext=1, alucontrol=000.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcen=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op:
    - 100011 lw, 101011 sw → MEMADR
    - 000000 R-type → RTYPEEX
    - 000100 beq → BEQEX
    - 000101 bne → BNEEX
    - 001000 addi → ADDIEX
    - 001100 andi → ANDIEX
    - 000010 j → JEX
    - any other op → FETCH (no side effects; PC already advanced)
  - MEMADR: lw→MEMRD, sw→MEMWR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX, ANDIEX→IMMWB.
  - MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX→FETCH.
- op, funct and zero are sampled every cycle. The IR holds op/funct stable after FETCH.
- Funct decode, used in RTYPEEX only:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - 000100 → 011
  - unknown funct → 010; writeback still occurs.
- Cycle counts from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi/andi 4, beq/bne/j 3, illegal 2.

Test Plan:
- Reset held 2 cycles mid-RTYPEEX, then released → state=0 on the next edge; pcen/irwrite/regwrite/memwrite=0 during reset; cycle after release shows pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
- op=100011 (lw) → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 only in state 3.
- op=000000, funct=100010, then funct=101010 → RTYPEEX alucontrol=110, then 111; RTYPEWB regdst=1, regwrite=1; sequence 0,1,6,7,0.
- op=000100 (beq) with zero=1 → pcen=1, pcsrc=01 in state 8; repeat with zero=0 → pcen=0; bne (000101) gives the inverse in state 13.
- op=001100 (andi) → states 0,1,12,10,0; zeroext=1 and alucontrol=000 in state 12; regdst=0, regwrite=1 in state 10.
- op=111111 (illegal) → states 0,1,0; no regwrite/memwrite ever asserted; op=000010 (j) → state 11 with pcsrc=10, pcen=1.
